vga_rx_monitor: RTL

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

---
 rtl/vga_rx_monitor.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive timing monitor with lock FSM and per-frame pixel statistics
module vga_rx_monitor #(
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int H_VIS  = 640,
    parameter int H_TOT  = 800,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int V_VIS  = 480,
    parameter int V_TOT  = 525
) (
    input  logic        clk_pix,
    input  logic        reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [3:0]  r_in,
    input  logic [3:0]  g_in,
    input  logic [3:0]  b_in,
    output logic        locked,
    output logic        rx_valid,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic [18:0] lit_count,
    output logic [7:0]  frame_count,
    output logic        h_err,
    output logic        v_err,
    output logic        blank_err
);

    localparam logic [9:0] CNT_MAX  = 10'h3FF;
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] H_PULSE  = 10'(H_SYNC);
    localparam logic [9:0] H_START  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_STOP   = 10'(H_SYNC + H_BP + H_VIS);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] V_PULSE  = 10'(V_SYNC);
    localparam logic [9:0] V_START  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_STOP   = 10'(V_SYNC + V_BP + V_VIS);

    typedef enum logic [1:0] {IDLE, ALIGN, CHECK, LOCKED} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        hs_r;
    logic        vs_r;
    logic        hs_d;
    logic [3:0]  r_r;
    logic [3:0]  g_r;
    logic [3:0]  b_r;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [9:0]  vlow_cnt;
    logic        vs_at_fall;
    logic [31:0] run_sum;
    logic [18:0] run_lit;

    logic        h_fall;
    logic        h_rise;
    logic        frame_start;
    logic        v_rise;
    logic [9:0]  cur_h;
    logic [9:0]  cur_v;
    logic        in_chk;
    logic        h_bad;
    logic        v_bad;
    logic        err_now;
    logic        vis;
    logic [11:0] pix;
    logic        good_end;

    // hcnt/vcnt hold the position of the previous registered sample; cur_h/cur_v
    // is the position of the sample sitting in the input registers right now.
    always_comb begin
        h_fall      = hs_d & ~hs_r;
        h_rise      = ~hs_d & hs_r;
        frame_start = h_fall & ~vs_r & vs_at_fall;
        v_rise      = h_fall & vs_r & ~vs_at_fall;
        cur_h       = h_fall ? 10'd0 : ((hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1);
        if (frame_start)
            cur_v = 10'd0;
        else if (h_fall)
            cur_v = (vcnt == CNT_MAX) ? vcnt : vcnt + 10'd1;
        else
            cur_v = vcnt;
        in_chk   = (state == CHECK) || (state == LOCKED);
        h_bad    = (h_fall && (hcnt != H_LAST)) || (h_rise && (cur_h != H_PULSE));
        v_bad    = (frame_start && (vcnt != V_LAST)) || (v_rise && (vlow_cnt != V_PULSE));
        err_now  = in_chk && (h_bad || v_bad);
        vis      = (cur_h >= H_START) && (cur_h < H_STOP) && (cur_v >= V_START) && (cur_v < V_STOP);
        pix      = {r_r, g_r, b_r};
        good_end = frame_start && in_chk && !err_now;
    end

    always_ff @(posedge clk_pix) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (h_fall) state_nxt = ALIGN;
            ALIGN:   if (frame_start) state_nxt = CHECK;
            CHECK:   if (err_now) state_nxt = ALIGN;
                     else if (frame_start) state_nxt = LOCKED;
            LOCKED:  if (err_now) state_nxt = ALIGN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    // Sync registers reset high so an idle-high sync never looks like a fall.
    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            hs_d        <= 1'b1;
            r_r         <= 4'd0;
            g_r         <= 4'd0;
            b_r         <= 4'd0;
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            vlow_cnt    <= 10'd0;
            vs_at_fall  <= 1'b1;
            run_sum     <= 32'd0;
            run_lit     <= 19'd0;
            rx_valid    <= 1'b0;
            rx_x        <= 10'd0;
            rx_y        <= 10'd0;
            frame_done  <= 1'b0;
            frame_sum   <= 32'd0;
            lit_count   <= 19'd0;
            frame_count <= 8'd0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            blank_err   <= 1'b0;
        end else begin
            hs_r <= hsync_in;
            vs_r <= vsync_in;
            hs_d <= hs_r;
            r_r  <= r_in;
            g_r  <= g_in;
            b_r  <= b_in;
            hcnt <= cur_h;
            vcnt <= cur_v;

            if (h_fall) begin
                vs_at_fall <= vs_r;
                if (frame_start)
                    vlow_cnt <= 10'd1;
                else if (!vs_r && (vlow_cnt != CNT_MAX))
                    vlow_cnt <= vlow_cnt + 10'd1;
            end

            if (frame_start) begin
                run_sum <= 32'd0;
                run_lit <= 19'd0;
            end else if (vis) begin
                run_sum <= run_sum + {20'd0, pix};
                if (pix != 12'd0)
                    run_lit <= run_lit + 19'd1;
            end

            rx_valid <= vis && in_chk;
            rx_x     <= (vis && in_chk) ? cur_h - H_START : 10'd0;
            rx_y     <= (vis && in_chk) ? cur_v - V_START : 10'd0;

            frame_done <= good_end;
            if (good_end) begin
                frame_sum   <= run_sum;
                lit_count   <= run_lit;
                frame_count <= frame_count + 8'd1;
            end

            if (in_chk && h_bad)
                h_err <= 1'b1;
            if (in_chk && v_bad)
                v_err <= 1'b1;
            if ((state == LOCKED) && !vis && (pix != 12'd0))
                blank_err <= 1'b1;
        end
    end

endmodule
